control_pipe: RTL
=================

Name: control_pipe

Overview:
- Consumes the ID-stage control word from the main decoder and carries it down the pipeline: ID/EX, then EX/MEM, then MEM/WB.
- Drives each stage's muxes and write enables from its own registered copy.
- Detects load-use hazards (stall), taken branches and jumps (flush), and generates EX-stage forwarding selects.
- Sits between the decoder and the datapath pipeline registers; holds no datapath values, only control and register indices.

Parameters:
- REG_W, 5, width of register-file addresses.
- ALUOP_W, 2, width of ALUOp.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_n  in  1  asynchronous active-low reset.
- RFWED, RFDSelD, ALUInSelD, BranchD, DMWED, MtoRFSelD, JumpD  in  1 each  decoder control bits, ID stage.
- ALUOpD  in  ALUOP_W  decoder ALUOp, ID stage.
- RsD, RtD, RdD  in  REG_W  register fields of the ID instruction.
- ZeroE  in  1  ALU zero flag, EX stage.
- StallF, StallD  out  1  hold PC / IF-ID register.
- FlushD  out  1  clear IF-ID register.
- PCSrcE  out  1  taken branch; select branch target.
- RFDSelE, ALUInSelE  out  1  EX mux selects.
- ALUOpE  out  ALUOP_W  EX ALU operation class.
- DMWEM  out  1  data memory write enable.
- MtoRFSelW, RFWEW  out  1  writeback mux select and register-file write enable.
- WriteRegE, WriteRegM, WriteRegW  out  REG_W  destination register per stage.
- ForwardAE, ForwardBE  out  2  00 = regfile, 10 = from MEM, 01 = from WB.

Behaviour:
- Reset (RST_n=0, asynchronous): every registered control bit and register index clears to 0 in all three stages (pipeline full of bubbles). All outputs read 0 while reset is held and on the first cycle after release.
- Stage registers:
  - ID/EX captures {RFWE, RFDSel, ALUInSel, Branch, DMWE, MtoRFSel, ALUOp, Rs, Rt, Rd} each edge.
  - EX/MEM captures {RFWE, DMWE, MtoRFSel, WriteRegE}.
  - MEM/WB captures {RFWE, MtoRFSel, WriteRegM}.
  - Each stage advances one cycle per edge; control latency from D to W is 3 edges.
- WriteRegE is combinational: RFDSelE ? RdE : RtE.
- Load-use hazard: lwstall = MtoRFSelE & RFWEE & ((RtE==RsD) | (RtE==RtD)).
  - On lwstall: StallF=1, StallD=1, and the ID/EX register loads a bubble (all control 0) next edge.
  - EX/MEM and MEM/WB advance normally.
- Branch: PCSrcE = BranchE & ZeroE. When PCSrcE=1:
  - FlushD=1.
  - ID/EX loads a bubble next edge.
  - StallF=StallD=0; branch flush overrides lwstall in the same cycle.
- Jump: JumpD=1 asserts FlushD=1 the same cycle and does not stall. JumpD is not pipelined. Simultaneous JumpD and PCSrcE: PCSrcE wins (the jump is wrong-path); FlushD=1 either way.
- Forwarding, operand A (operand B identical using RtE):
  - 10 if RFWEM & WriteRegM!=0 & WriteRegM==RsE.
  - Else 01 if RFWEW & WriteRegW!=0 & WriteRegW==RsE.
  - Else 00.
  - MEM has priority over WB.
  - Register 0 never forwards.
- Unknown opcodes (decoder drives X control): no special handling. Any cycle that loads a bubble forces known zeros regardless of inputs.
- A reset assertion mid-stall or mid-flush clears all state immediately; there is no residual stall after release.

Test Plan:
- Reset: hold RST_n=0 for 3 cycles with arbitrary inputs, then release -> all outputs 0, ForwardAE=ForwardBE=00, first D instruction reaches RFWEW after 3 edges.
- R-type chain: add $3 in D (RFDSelD=1, RdD=3) followed by an instruction with RsD=3 -> one cycle later ForwardAE=10; with a NOP in between -> ForwardAE=01.
- Load-use: LW $5 in E (MtoRFSelE=1, RtE=5), D has RtD=5 -> StallF=StallD=1 for exactly 1 cycle; next cycle ALUOpE=00 and RFWEE=0 (bubble), then the consumer enters E with ForwardBE=01.
- Taken branch: BranchE=1, ZeroE=1 coincident with a lwstall condition -> PCSrcE=1, FlushD=1, StallF=0, next-cycle ID/EX all zero; repeat with ZeroE=0 -> PCSrcE=0, no flush.
- Jump: JumpD=1 -> FlushD=1 same cycle, StallF=0; the next D slot arrives as a bubble in E.
- Zero-register guard: RFWEM=1, WriteRegM=0, RsE=0 -> ForwardAE=00; SW in pipe -> DMWEM=1 exactly 2 edges after DMWED, RFWEW stays 0.

Source files
------------

// File: rtl/control_pipe.sv
// control_pipe: ID->EX->MEM->WB control word pipeline with
// load-use stall, branch/jump flush and EX forwarding selects.
module control_pipe #(
    parameter int REG_W   = 5,
    parameter int ALUOP_W = 2
) (
    input  logic               CLK,
    input  logic               RST_n,
    input  logic               RFWED,
    input  logic               RFDSelD,
    input  logic               ALUInSelD,
    input  logic               BranchD,
    input  logic               DMWED,
    input  logic               MtoRFSelD,
    input  logic               JumpD,
    input  logic [ALUOP_W-1:0] ALUOpD,
    input  logic [REG_W-1:0]   RsD,
    input  logic [REG_W-1:0]   RtD,
    input  logic [REG_W-1:0]   RdD,
    input  logic               ZeroE,
    output logic               StallF,
    output logic               StallD,
    output logic               FlushD,
    output logic               PCSrcE,
    output logic               RFDSelE,
    output logic               ALUInSelE,
    output logic [ALUOP_W-1:0] ALUOpE,
    output logic               DMWEM,
    output logic               MtoRFSelW,
    output logic               RFWEW,
    output logic [REG_W-1:0]   WriteRegE,
    output logic [REG_W-1:0]   WriteRegM,
    output logic [REG_W-1:0]   WriteRegW,
    output logic [1:0]         ForwardAE,
    output logic [1:0]         ForwardBE
);

    typedef struct packed {
        logic               rfwe;
        logic               rfdsel;
        logic               aluinsel;
        logic               branch;
        logic               dmwe;
        logic               mtorf;
        logic [ALUOP_W-1:0] aluop;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
    } id_ex_t;

    typedef struct packed {
        logic             rfwe;
        logic             dmwe;
        logic             mtorf;
        logic [REG_W-1:0] wr;
    } ex_mem_t;

    typedef struct packed {
        logic             rfwe;
        logic             mtorf;
        logic [REG_W-1:0] wr;
    } mem_wb_t;

    id_ex_t  id_ex_q,  id_ex_d;
    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;

    logic lwstall;
    logic bubble;

    // MEM result is newer than WB, so it wins; $0 is hardwired and never forwards
    function automatic logic [1:0] fwd_sel(
        input logic             m_we,
        input logic [REG_W-1:0] m_wr,
        input logic             w_we,
        input logic [REG_W-1:0] w_wr,
        input logic [REG_W-1:0] src
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (m_we && (m_wr != '0) && (m_wr == src)) begin
            sel = 2'b10;
        end else if (w_we && (w_wr != '0) && (w_wr == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        lwstall = id_ex_q.mtorf & id_ex_q.rfwe &
                  ((id_ex_q.rt == RsD) | (id_ex_q.rt == RtD));
        PCSrcE  = id_ex_q.branch & ZeroE;
        bubble  = lwstall | PCSrcE;
        StallF  = lwstall & ~PCSrcE;
        StallD  = lwstall & ~PCSrcE;
        FlushD  = RST_n & (PCSrcE | JumpD);
    end

    always_comb begin
        id_ex_d = '0;
        if (!bubble) begin
            id_ex_d.rfwe     = RFWED;
            id_ex_d.rfdsel   = RFDSelD;
            id_ex_d.aluinsel = ALUInSelD;
            id_ex_d.branch   = BranchD;
            id_ex_d.dmwe     = DMWED;
            id_ex_d.mtorf    = MtoRFSelD;
            id_ex_d.aluop    = ALUOpD;
            id_ex_d.rs       = RsD;
            id_ex_d.rt       = RtD;
            id_ex_d.rd       = RdD;
        end
    end

    always_comb begin
        WriteRegE      = id_ex_q.rfdsel ? id_ex_q.rd : id_ex_q.rt;
        ex_mem_d.rfwe  = id_ex_q.rfwe;
        ex_mem_d.dmwe  = id_ex_q.dmwe;
        ex_mem_d.mtorf = id_ex_q.mtorf;
        ex_mem_d.wr    = WriteRegE;
        mem_wb_d.rfwe  = ex_mem_q.rfwe;
        mem_wb_d.mtorf = ex_mem_q.mtorf;
        mem_wb_d.wr    = ex_mem_q.wr;
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    always_comb begin
        RFDSelE   = id_ex_q.rfdsel;
        ALUInSelE = id_ex_q.aluinsel;
        ALUOpE    = id_ex_q.aluop;
        DMWEM     = ex_mem_q.dmwe;
        WriteRegM = ex_mem_q.wr;
        MtoRFSelW = mem_wb_q.mtorf;
        RFWEW     = mem_wb_q.rfwe;
        WriteRegW = mem_wb_q.wr;
        ForwardAE = fwd_sel(ex_mem_q.rfwe, ex_mem_q.wr,
                            mem_wb_q.rfwe, mem_wb_q.wr, id_ex_q.rs);
        ForwardBE = fwd_sel(ex_mem_q.rfwe, ex_mem_q.wr,
                            mem_wb_q.rfwe, mem_wb_q.wr, id_ex_q.rt);
    end

endmodule
